// File: rtl/ps_rb_pkg.sv
// rtl/ps_rb_pkg.sv - shared constants, FSM state type and offset-binary conversion for the PS readback decoder
//
// Contents:
//   DW, ST_W          readback data width and status width of one frame
//   FRAME_BITS        strobes per frame (status bits first, then data, MSB first)
//   TIMEOUT_CYC_DEF   default max clk cycles between strobes inside a frame
//   OB_OFFSET         offset-binary zero point, 2^(DW-1)
//   state_e           IDLE / SHIFT / CONV
//   ob2tc()           offset-binary to two's complement (MSB inversion)

package ps_rb_pkg;

   localparam int DW              = 20;
   localparam int ST_W            = 4;
   localparam int FRAME_BITS      = ST_W + DW;
   localparam int CNT_W           = $clog2(FRAME_BITS + 1);
   localparam int TIMEOUT_CYC_DEF = 255;

   localparam logic [DW-1:0] OB_OFFSET = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CONV  = 2'd2
   } state_e;

   // Subtracting 2^(DW-1) modulo 2^DW only flips the MSB, so the mapping is
   // exact over the whole code range and never needs saturation.
   function automatic logic [DW-1:0] ob2tc(input logic [DW-1:0] ob);
      return {~ob[DW-1], ob[DW-2:0]};
   endfunction

endpackage

// File: rtl/ps_rb_boxcar.sv
// rtl/ps_rb_boxcar.sv - 4-sample boxcar averager for accepted readback words
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_valid_i     a word is accepted this cycle (updates the history)
//   in_data_i      accepted signed word
//   avg_next_o     average including in_data_i, floor((sum)/4)
//   primed_next_o  high once in_data_i is at least the 4th accepted word

module ps_rb_boxcar
   import ps_rb_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid_i,
   input  logic [DW-1:0] in_data_i,
   output logic [DW-1:0] avg_next_o,
   output logic          primed_next_o
);

   logic [DW+1:0]        sum_q;
   logic [DW+1:0]        sum_d;
   logic [3:0][DW-1:0]   hist_q;
   logic [2:0]           cnt_q;

   // History starts at zero, so the oldest entry can always be subtracted;
   // modular wrap of the intermediate is harmless because the true 4-word
   // sum always fits in DW+2 bits.
   assign sum_d = sum_q
                - {{2{hist_q[3][DW-1]}}, hist_q[3]}
                + {{2{in_data_i[DW-1]}}, in_data_i};

   // Dropping the two LSBs of the sign-correct sum is an arithmetic shift,
   // i.e. rounding toward negative infinity.
   assign avg_next_o    = sum_d[DW+1:2];
   assign primed_next_o = (cnt_q >= 3'd3);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q  <= '0;
         hist_q <= '0;
         cnt_q  <= '0;
      end else if (in_valid_i) begin
         sum_q  <= sum_d;
         hist_q <= {hist_q[2:0], in_data_i};
         if (cnt_q != 3'd4) begin
            cnt_q <= cnt_q + 3'd1;
         end
      end
   end

endmodule

// File: rtl/ps_readback_decoder.sv
// rtl/ps_readback_decoder.sv - deserializes PS readback frames and converts offset-binary to two's complement
//
// Optional feature: define PS_RB_AVG_EN to pass accepted words through a
// 4-sample boxcar (ps_rb_boxcar) before they reach two_comp.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   sdi_en         bit strobe; sdi/sfs sampled only when high
//   sdi            serial data, MSB first (status bits, then data)
//   sfs            frame sync, high on the strobe of the first frame bit
//   out_ready      downstream accept
//   out_valid      readback word available
//   two_comp       signed readback word
//   ps_status      status bits of the same frame
//   frame_err      one-cycle pulse on an aborted frame
//   ovf_cnt        saturating count of dropped words

module ps_readback_decoder
   import ps_rb_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sdi_en,
   input  logic            sdi,
   input  logic            sfs,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [DW-1:0]   two_comp,
   output logic [ST_W-1:0] ps_status,
   output logic            frame_err,
   output logic [7:0]      ovf_cnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_e                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic                    out_valid_q, out_valid_d;
   logic [DW-1:0]           two_comp_q, two_comp_d;
   logic [ST_W-1:0]         ps_status_q, ps_status_d;
   logic                    frame_err_q, frame_err_d;
   logic [7:0]              ovf_cnt_q, ovf_cnt_d;
   logic [DW-1:0]           conv_word;

   assign conv_word = ob2tc(shift_q[DW-1:0]);

`ifdef PS_RB_AVG_EN
   logic          accept;
   logic [DW-1:0] avg_next;
   logic          avg_primed_next;

   ps_rb_boxcar u_boxcar (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid_i    (accept),
      .in_data_i     (conv_word),
      .avg_next_o    (avg_next),
      .primed_next_o (avg_primed_next)
   );
`endif

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_d       = '0;
      out_valid_d = out_valid_q;
      two_comp_d  = two_comp_q;
      ps_status_d = ps_status_q;
      frame_err_d = 1'b0;
      ovf_cnt_d   = ovf_cnt_q;
`ifdef PS_RB_AVG_EN
      accept      = 1'b0;
`endif

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         SHIFT: begin
            if (sdi_en) begin
               if (sfs) begin
                  // Early sync: abort the partial frame, this bit is bit 0.
                  frame_err_d = 1'b1;
                  shift_d     = {{(FRAME_BITS-1){1'b0}}, sdi};
                  bit_cnt_d   = CNT_W'(1);
               end else begin
                  shift_d   = {shift_q[FRAME_BITS-2:0], sdi};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                     state_d = CONV;
                  end
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               frame_err_d = 1'b1;
               bit_cnt_d   = '0;
               state_d     = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            // IDLE and CONV share the frame-start detection so a sync strobe
            // arriving during the conversion cycle is not lost.
            if (state_q == CONV) begin
               if (!out_valid_q || out_ready) begin
`ifdef PS_RB_AVG_EN
                  accept      = 1'b1;
                  two_comp_d  = avg_next;
                  out_valid_d = avg_primed_next;
`else
                  two_comp_d  = conv_word;
                  out_valid_d = 1'b1;
`endif
                  ps_status_d = shift_q[FRAME_BITS-1 -: ST_W];
               end else if (ovf_cnt_q != 8'hFF) begin
                  ovf_cnt_d = ovf_cnt_q + 8'd1;
               end
            end
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (sdi_en && sfs) begin
               shift_d   = {{(FRAME_BITS-1){1'b0}}, sdi};
               bit_cnt_d = CNT_W'(1);
               state_d   = SHIFT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         tmo_q       <= '0;
         out_valid_q <= 1'b0;
         two_comp_q  <= '0;
         ps_status_q <= '0;
         frame_err_q <= 1'b0;
         ovf_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_q       <= tmo_d;
         out_valid_q <= out_valid_d;
         two_comp_q  <= two_comp_d;
         ps_status_q <= ps_status_d;
         frame_err_q <= frame_err_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign two_comp  = two_comp_q;
   assign ps_status = ps_status_q;
   assign frame_err = frame_err_q;
   assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_ps_readback_decoder.sv
// tb/tb_ps_readback_decoder.sv - scoreboard testbench for ps_readback_decoder

module tb_ps_readback_decoder;
   import ps_rb_pkg::*;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            sdi_en = 1'b0;
   logic            sdi = 1'b0;
   logic            sfs = 1'b0;
   logic            out_ready = 1'b1;
   logic            out_valid;
   logic [DW-1:0]   two_comp;
   logic [ST_W-1:0] ps_status;
   logic            frame_err;
   logic [7:0]      ovf_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int err_pulses = 0;
   int e0;

   typedef struct packed {
      logic [ST_W-1:0] st;
      logic [DW-1:0]   tc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   ps_readback_decoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sdi_en    (sdi_en),
      .sdi       (sdi),
      .sfs       (sfs),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .two_comp  (two_comp),
      .ps_status (ps_status),
      .frame_err (frame_err),
      .ovf_cnt   (ovf_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake, sampled at negedge.
   always @(negedge clk) begin
      if (reset_n && frame_err) err_pulses++;
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got st=0x%0h tc=0x%0h, expected no word", ps_status, two_comp);
         end else begin
            mon_e = exp_q.pop_front();
            check("word_tc", 32'(two_comp), 32'(mon_e.tc));
            check("word_st", 32'(ps_status), 32'(mon_e.st));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic f, input logic b);
      sdi_en = 1'b1;
      sfs    = f;
      sdi    = b;
      tick(1);
      sdi_en = 1'b0;
      sfs    = 1'b0;
      sdi    = 1'b0;
   endtask

   task automatic send_bits(input logic [ST_W-1:0] st, input logic [DW-1:0] d, input int nbits);
      logic [FRAME_BITS-1:0] fr;
      fr = {st, d};
      for (int i = 0; i < nbits; i++) begin
         strobe(i == 0, fr[FRAME_BITS-1-i]);
      end
   endtask

   task automatic send_checked(input logic [ST_W-1:0] st, input logic [DW-1:0] d, input logic [DW-1:0] tc);
      exp_q.push_back({st, tc});
      send_bits(st, d, FRAME_BITS);
      check("lat_clk1_valid", 32'(out_valid), 32'd0);
      tick(1);
      check("lat_clk2_valid", 32'(out_valid), 32'd1);
      tick(2);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      out_ready = 1'b1;
      tick(2);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_tc", 32'(two_comp), 32'd0);
      check("rst_st", 32'(ps_status), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_ovf", 32'(ovf_cnt), 32'd0);
      reset_n = 1'b1;
      tick(1);

`ifdef PS_RB_AVG_EN
      // Words 4, 8, -4, 0: no output until the 4th, then (4+8-4+0)/4 = 2.
      send_bits(4'h0, 20'h80004, FRAME_BITS);
      send_bits(4'h0, 20'h80008, FRAME_BITS);
      send_bits(4'h0, 20'h7FFFC, FRAME_BITS);
      tick(3);
      check("avg_not_primed", 32'(out_valid), 32'd0);
      exp_q.push_back({4'h0, 20'h00002});
      send_bits(4'h0, 20'h80000, FRAME_BITS);
      tick(3);
      drain();
      // Accept 16 -> (8-4+0+16)/4 = 5; drop 32; then 0 -> (-4+0+16+0)/4 = 3.
      out_ready = 1'b0;
      exp_q.push_back({4'h0, 20'h00005});
      send_bits(4'h0, 20'h80010, FRAME_BITS);
      tick(3);
      check("avg_hold_valid", 32'(out_valid), 32'd1);
      check("avg_hold_tc", 32'(two_comp), 32'h00005);
      send_bits(4'h0, 20'h80020, FRAME_BITS);
      tick(3);
      check("avg_ovf", 32'(ovf_cnt), 32'd1);
      check("avg_hold_tc2", 32'(two_comp), 32'h00005);
      exp_q.push_back({4'h0, 20'h00003});
      out_ready = 1'b1;
      tick(2);
      send_bits(4'h0, 20'h80000, FRAME_BITS);
      tick(3);
      drain();
`else
      // Basic conversions, with 2-clk latency checked on each.
      send_checked(4'hA, 20'h80000, 20'h00000);
      send_checked(4'h5, 20'hFFFFF, 20'h7FFFF);
      send_checked(4'h0, 20'h00000, 20'h80000);
      send_checked(4'hF, 20'h7FFFF, 20'hFFFFF);

      // Back-pressure: first word held, next two dropped.
      out_ready = 1'b0;
      exp_q.push_back({4'h3, 20'h00001});
      send_bits(4'h3, 20'h80001, FRAME_BITS);
      send_bits(4'h3, 20'h80002, FRAME_BITS);
      send_bits(4'h3, 20'h80003, FRAME_BITS);
      tick(3);
      check("bp_ovf", 32'(ovf_cnt), 32'd2);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_tc", 32'(two_comp), 32'h00001);
      check("bp_st", 32'(ps_status), 32'h3);
      tick(5);
      check("bp_tc_later", 32'(two_comp), 32'h00001);
      out_ready = 1'b1;
      tick(1);
      check("bp_valid_clear", 32'(out_valid), 32'd0);
      send_checked(4'h3, 20'h80004, 20'h00004);
      drain();

      // Sync re-asserted at bit 10.
      e0 = err_pulses;
      send_bits(4'h6, 20'h12345, 10);
      exp_q.push_back({4'h9, 20'h2BCDE});
      send_bits(4'h9, 20'hABCDE, FRAME_BITS);
      tick(3);
      check("resync_err_pulses", 32'(err_pulses - e0), 32'd1);
      drain();

      // Strobes stop mid-frame: error exactly after 255 idle cycles.
      e0 = err_pulses;
      send_bits(4'h1, 20'h55555, 12);
      tick(254);
      check("tmo_early", 32'(err_pulses - e0), 32'd0);
      tick(2);
      check("tmo_err_pulses", 32'(err_pulses - e0), 32'd1);
      check("tmo_no_valid", 32'(out_valid), 32'd0);
      strobe(1'b0, 1'b1);
      strobe(1'b0, 1'b1);
      strobe(1'b0, 1'b0);
      tick(1);
      send_checked(4'h2, 20'h00001, 20'h80001);
      drain();

      // Reset pulse at bit 15: outputs clear immediately.
      send_bits(4'h7, 20'h0F0F0, 15);
      reset_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_tc", 32'(two_comp), 32'd0);
      check("midrst_st", 32'(ps_status), 32'd0);
      check("midrst_ovf", 32'(ovf_cnt), 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      send_checked(4'hC, 20'h0F0F0, 20'h8F0F0);
      check("midrst_ovf_after", 32'(ovf_cnt), 32'd0);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
